// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and the
// counter width helper.
package serial_sub_pkg;

    // FSM state encoding; 2'd3 is unused and recovers to IDLE
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Bit-index counter width: $clog2(width), never less than one bit
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and data bundle for serial_subtractor.
// master = controller side, slave = subtractor side.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero_flag;
    logic             ovf_flag;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, zero_flag, ovf_flag
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, zero_flag, ovf_flag
    );
endinterface

// File: rtl/serial_subtractor_bit_cell.sv
// Combinational one-bit full subtractor: d = x - y - bin, with borrow out.
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), one bit per clock,
// LSB first, using a single full-subtractor cell and a borrow flip-flop.
// Sequence: IDLE -> RUN (WIDTH cycles) -> DONE (one cycle, done pulse) -> IDLE.
// Optional feature macro: SERIAL_SUBTRACTOR_FLAGS_EN enables the registered
// zero and signed-overflow flags; without it both flags are tied low.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_borrow_out;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_diff_next;

    assign w_accept    = (r_state == S_IDLE) && bus.start;
    assign w_run       = (r_state == S_RUN);
    assign w_last      = w_run && (r_cnt == CNT_LAST);
    // New result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
    assign w_diff_next = {w_d, r_diff[WIDTH-1:1]};

    sub_bit_cell u_cell (
        .x    (r_a_sh[0]),
        .y    (r_b_sh[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    // Control FSM: accept in IDLE, WIDTH bit cycles in RUN, one DONE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.start) r_state <= S_RUN;
                S_RUN:   if (r_cnt == CNT_LAST) r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand/result shift registers, bit counter and borrow flip-flop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_diff       <= '0;
            r_br         <= 1'b0;
            r_borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_a_sh <= bus.a;
            r_b_sh <= bus.b;
            r_br   <= 1'b0;
        end else if (w_run) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_br   <= w_bout;
            r_diff <= w_diff_next;
            // Counter parks on the last index rather than wrapping
            if (!w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_borrow_out <= w_bout;
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_zero;
    logic r_ovf;

    // Operand MSB capture and flag update on the final bit, visible in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
        end else if (w_last) begin
            r_zero <= (w_diff_next == '0);
            // Overflow only possible when operand signs differ; w_d is the result MSB
            r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign bus.zero_flag = r_zero;
    assign bus.ovf_flag  = r_ovf;
`else
    assign bus.zero_flag = 1'b0;
    assign bus.ovf_flag  = 1'b0;
`endif

    assign bus.busy       = (r_state == S_RUN) || (r_state == S_DONE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): the driver pushes the
// reference result of every accepted start; the monitor pops on each done pulse.
module tb_serial_subtractor;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
        logic         ovf;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_subtractor_if #(.WIDTH(W)) sif ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    int   cyc   = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   = cyc + 1;
        rst_q = rst;
    end

    exp_t sb_q[$];

    // Reference: plain integer arithmetic on the operands
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        int ua, ub, sa, sb, sd;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 2 ** (W - 1)) ? ua - 2 ** W : ua;
        sb = (ub >= 2 ** (W - 1)) ? ub - 2 ** W : ub;
        sd = sa - sb;
        e.diff   = W'(ua - ub);
        e.borrow = (ua < ub);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        e.zero = ((ua - ub) % (2 ** W) == 0);
        e.ovf  = (sd > 2 ** (W - 1) - 1) || (sd < -(2 ** (W - 1)));
`else
        e.zero = 1'b0;
        e.ovf  = 1'b0;
        if (sd == 0) e.zero = 1'b0;
`endif
        e.acc = acc;
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int           total = 0;
    int           bad   = 0;
    int           busy_run = 0;
    logic [W-1:0] h_diff   = '0;
    logic         h_borrow = 1'b0;
    logic         h_zero   = 1'b0;
    logic         h_ovf    = 1'b0;
    exp_t         e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_q) begin
            sb_q.delete();
            h_diff   = '0;
            h_borrow = 1'b0;
            h_zero   = 1'b0;
            h_ovf    = 1'b0;
            busy_run = 0;
            chk("rst_busy",   32'(sif.busy),       0);
            chk("rst_done",   32'(sif.done),       0);
            chk("rst_diff",   32'(sif.diff),       0);
            chk("rst_borrow", 32'(sif.borrow_out), 0);
            chk("rst_zero",   32'(sif.zero_flag),  0);
            chk("rst_ovf",    32'(sif.ovf_flag),   0);
        end else begin
            if (sif.done) begin
                chk("done_busy", 32'(sif.busy), 1);
                if (sb_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("latency", 32'(cyc - e.acc), W);
                    chk("diff",    32'(sif.diff),       32'(e.diff));
                    chk("borrow",  32'(sif.borrow_out), 32'(e.borrow));
                    chk("zero",    32'(sif.zero_flag),  32'(e.zero));
                    chk("ovf",     32'(sif.ovf_flag),   32'(e.ovf));
                    h_diff   = e.diff;
                    h_borrow = e.borrow;
                    h_zero   = e.zero;
                    h_ovf    = e.ovf;
                end
            end else if (sb_q.size() != 0 && (cyc - sb_q[0].acc) > W) begin
                chk("done_timeout", 32'(cyc - sb_q[0].acc), W);
                void'(sb_q.pop_front());
            end
            if (!sif.busy) begin
                busy_run = 0;
                chk("hold_diff",   32'(sif.diff),       32'(h_diff));
                chk("hold_borrow", 32'(sif.borrow_out), 32'(h_borrow));
                chk("hold_zero",   32'(sif.zero_flag),  32'(h_zero));
                chk("hold_ovf",    32'(sif.ovf_flag),   32'(h_ovf));
            end else begin
                busy_run = busy_run + 1;
                if (busy_run > W + 1) begin
                    chk("busy_stuck", 32'(busy_run), W + 1);
                    busy_run = 0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic st, input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ir);
        @(negedge clk);
        if (st && !sif.busy && !ir) sb_q.push_back(model(ia, ib, cyc + 1));
        sif.start = st;
        sif.a     = ia;
        sif.b     = ib;
        rst       = ir;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3 * W + 10; i++) begin
            step(1'b0, W'($urandom), W'($urandom), 1'b0);
            if (!sif.busy && sb_q.size() == 0) break;
        end
    endtask

    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib);
        step(1'b1, ia, ib, 1'b0);
        wait_idle();
    endtask

    initial begin
        sif.start = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0);

        op(4'd9, 4'd3);
        op(4'd3, 4'd9);
        op(4'd5, 4'd5);
        op(4'h8, 4'd1);
        op(4'h7, 4'hF);
        op(4'h0, 4'h0);

        // start held high; operands toggle while busy and only 7/2 is offered when idle
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!sif.busy) begin
                sb_q.push_back(model(4'd7, 4'd2, cyc + 1));
                sif.a = 4'd7;
                sif.b = 4'd2;
            end else begin
                sif.a = W'($urandom);
                sif.b = W'($urandom);
            end
            sif.start = 1'b1;
        end
        step(1'b0, '0, '0, 1'b0);
        wait_idle();

        // reset two edges after an accepted start aborts the op
        step(1'b1, 4'd12, 4'd3, 1'b0);
        step(1'b0, W'($urandom), W'($urandom), 1'b0);
        step(1'b0, W'($urandom), W'($urandom), 1'b1);
        step(1'b0, '0, '0, 1'b0);
        op(4'd6, 4'd1);

        // random traffic, including starts issued while busy
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) == 0, W'($urandom), W'($urandom), 1'b0);
        end
        wait_idle();
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
